// File: rtl/hbridge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hbridge_ctrl
// Brief    : H-bridge direction/brake controller with enforced dead time and
//            registered outputs. Define HBRIDGE_WDOG_EN to add the stuck-high
//            PWM watchdog and its latched FAULT state.
// Revision : 1.0 - initial release
// ============================================================================
module hbridge_ctrl #(
    parameter int DEAD_CYCLES = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic pwm_in,
    input  logic enable,
    input  logic dir_req,
    input  logic brake,
    output logic in1,
    output logic in2,
    output logic busy,
    output logic fault
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_DEAD  = 3'd1;
    localparam logic [2:0] c_DRIVE = 3'd2;
    localparam logic [2:0] c_BRAKE = 3'd3;
`ifdef HBRIDGE_WDOG_EN
    localparam logic [2:0] c_FAULT = 3'd4;
`endif

    localparam logic [7:0] c_DEAD_LOAD = 8'(DEAD_CYCLES - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_dead_cnt;
    logic [7:0] w_dead_nxt;
    logic       r_dir_q;
    logic       w_dir_nxt;
    logic       w_in_fault;
    logic       w_wdog_hit;

    logic       w_in1;
    logic       w_in2;
    logic       w_busy;
    logic       r_in1;
    logic       r_in2;
    logic       r_busy;

`ifdef HBRIDGE_WDOG_EN
    localparam logic [15:0] c_WDOG_LAST = 16'(WDOG_CYCLES - 1);

    logic [15:0] r_wdog_cnt;
    logic        r_fault;

    // Counts only uninterrupted pwm-high cycles spent in DRIVE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wdog_cnt <= '0;
        end else if (r_state == c_DRIVE && pwm_in) begin
            r_wdog_cnt <= r_wdog_cnt + 16'd1;
        end else begin
            r_wdog_cnt <= '0;
        end
    end

    assign w_wdog_hit = (r_state == c_DRIVE) && pwm_in && (r_wdog_cnt == c_WDOG_LAST);
    assign w_in_fault = (r_state == c_FAULT);
`else
    assign w_wdog_hit = 1'b0;
    assign w_in_fault = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_dead_cnt <= '0;
            r_dir_q    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dead_cnt <= w_dead_nxt;
            r_dir_q    <= w_dir_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_dead_nxt  = r_dead_cnt;
        w_dir_nxt   = r_dir_q;
        case (r_state)
            c_IDLE: begin
                if (enable) begin
                    w_state_nxt = c_DEAD;
                    w_dead_nxt  = c_DEAD_LOAD;
                end
            end
            c_DEAD: begin
                // dir_req and brake are only looked at on the exit edge.
                if (r_dead_cnt == 8'd0) begin
                    w_state_nxt = brake ? c_BRAKE : c_DRIVE;
                    w_dir_nxt   = dir_req;
                end else begin
                    w_dead_nxt = r_dead_cnt - 8'd1;
                end
            end
            c_DRIVE: begin
                if (w_wdog_hit) begin
`ifdef HBRIDGE_WDOG_EN
                    w_state_nxt = c_FAULT;
`endif
                end else if (brake || (dir_req != r_dir_q)) begin
                    w_state_nxt = c_DEAD;
                    w_dead_nxt  = c_DEAD_LOAD;
                end
            end
            c_BRAKE: begin
                if (!brake) begin
                    w_state_nxt = c_DEAD;
                    w_dead_nxt  = c_DEAD_LOAD;
                end
            end
            default: begin
                if (!w_in_fault) begin
                    w_state_nxt = c_IDLE;
                end
            end
        endcase
        // Dropping enable wins over everything except a latched fault.
        if (!enable && !w_in_fault) begin
            w_state_nxt = c_IDLE;
            w_dead_nxt  = '0;
        end
    end

    // Output decode from the current state; registered below.
    always_comb begin
        w_in1  = 1'b0;
        w_in2  = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            c_DEAD: begin
                w_busy = 1'b1;
            end
            c_DRIVE: begin
                w_in1 = pwm_in & ~r_dir_q;
                w_in2 = pwm_in &  r_dir_q;
            end
            c_BRAKE: begin
                w_in1 = 1'b1;
                w_in2 = 1'b1;
            end
            default: begin
                w_in1 = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_in1  <= 1'b0;
            r_in2  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_in1  <= w_in1;
            r_in2  <= w_in2;
            r_busy <= w_busy;
        end
    end

`ifdef HBRIDGE_WDOG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_in_fault;
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    assign in1  = r_in1;
    assign in2  = r_in2;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_hbridge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hbridge_ctrl
// Brief    : Directed scoreboard bench for hbridge_ctrl; the driver queues the
//            hand-derived output for each cycle and a monitor compares it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hbridge_ctrl;

    localparam int DEAD_CYCLES = 16;
    localparam int WDOG_CYCLES = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic pwm_in = 1'b0;
    logic enable = 1'b0;
    logic dir_req = 1'b0;
    logic brake = 1'b0;
    logic in1;
    logic in2;
    logic busy;
    logic fault;

    typedef struct {
        string      name;
        logic [3:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    hbridge_ctrl #(
        .DEAD_CYCLES (DEAD_CYCLES),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .pwm_in  (pwm_in),
        .enable  (enable),
        .dir_req (dir_req),
        .brake   (brake),
        .in1     (in1),
        .in2     (in2),
        .busy    (busy),
        .fault   (fault)
    );

    always #5 clock = ~clock;

    // Apply one cycle of inputs; exp is {in1,in2,busy,fault} after the next edge.
    task automatic drive(input logic rst, input logic en, input logic dir,
                         input logic brk, input logic pwm,
                         input logic [3:0] exp, input string name);
        exp_t e;
        @(negedge clock);
        reset   = rst;
        enable  = en;
        dir_req = dir;
        brake   = brk;
        pwm_in  = pwm;
        e.name  = name;
        e.exp   = exp;
        exp_q.push_back(e);
    endtask

    // Monitor: scoreboard compare plus a shoot-through pattern checker.
    initial begin
        logic [1:0] prev;
        logic [1:0] cur;
        exp_t       e;
        prev = 2'b00;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({in1, in2, busy, fault} !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got in1/in2/busy/fault=%b required %b at %0t",
                             e.name, {in1, in2, busy, fault}, e.exp, $time);
                end
            end
            cur = {in1, in2};
            if (!$isunknown({cur, busy})) begin
                checks++;
                if ((cur == 2'b11 && busy) ||
                    (prev != cur && prev != 2'b00 && cur != 2'b00)) begin
                    errors++;
                    $display("FAIL shoot_through: in1/in2 went %b -> %b (busy=%b) required a zero gap at %0t",
                             prev, cur, busy, $time);
                end
                prev = cur;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic p;

        // Reset and idle
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 4'b0000, "reset");
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 4'b0000, "idle");

        // Enable forward: 16 busy cycles then in1 tracks pwm
        drive(0, 1, 0, 0, 0, 4'b0000, "idle_to_dead");
        for (int i = 0; i < DEAD_CYCLES; i++) begin
            p = 1'(i & 1);
            drive(0, 1, 0, 0, p, 4'b0010, "dead_start");
        end
        for (int i = 0; i < 8; i++) begin
            p = 1'(i & 1);
            drive(0, 1, 0, 0, p, {p, 3'b000}, "drive_fwd");
        end

        // Direction change, with a brake glitch mid-DEAD that must be ignored
        drive(0, 1, 1, 0, 1, 4'b1000, "fwd_dir_change");
        for (int i = 0; i < DEAD_CYCLES; i++) begin
            drive(0, 1, 1, (i == 5) ? 1'b1 : 1'b0, 1, 4'b0010, "dead_dir");
        end
        for (int i = 0; i < 6; i++) begin
            p = 1'(~i & 1);
            drive(0, 1, 1, 0, p, {1'b0, p, 2'b00}, "drive_rev");
        end

        // Brake entry and release
        drive(0, 1, 1, 1, 1, 4'b0100, "rev_brake_req");
        for (int i = 0; i < DEAD_CYCLES; i++) drive(0, 1, 1, 1, 0, 4'b0010, "dead_to_brake");
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 0, 4'b1100, "brake");
        drive(0, 1, 1, 0, 0, 4'b1100, "brake_release");
        for (int i = 0; i < DEAD_CYCLES; i++) drive(0, 1, 1, 0, 1, 4'b0010, "dead_from_brake");
        for (int i = 0; i < 4; i++) begin
            p = 1'(i & 1);
            drive(0, 1, 1, 0, p, {1'b0, p, 2'b00}, "drive_rev_resume");
        end

        // enable=0 mid-DEAD
        drive(0, 1, 0, 0, 0, 4'b0000, "rev_dir_change");
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 4'b0010, "dead_partial");
        drive(0, 0, 0, 0, 0, 4'b0010, "dead_disable");
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 4'b0000, "idle_after_dead");

        // enable=0 mid-BRAKE
        drive(0, 1, 0, 1, 0, 4'b0000, "idle_to_dead_brk");
        for (int i = 0; i < DEAD_CYCLES; i++) drive(0, 1, 0, 1, 1, 4'b0010, "dead_brk");
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 1, 4'b1100, "brake2");
        drive(0, 0, 0, 1, 1, 4'b1100, "brake_disable");
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 4'b0000, "idle_after_brake");

        // Reset in DRIVE with brake and dir_req changing together
        drive(0, 1, 0, 0, 0, 4'b0000, "idle_to_dead2");
        for (int i = 0; i < DEAD_CYCLES; i++) drive(0, 1, 0, 0, 1, 4'b0010, "dead2");
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 1, 4'b1000, "drive_fwd_high");
        drive(1, 1, 1, 1, 1, 4'b0000, "reset_in_drive");
        drive(1, 0, 0, 0, 0, 4'b0000, "reset_hold");
        drive(0, 0, 0, 0, 0, 4'b0000, "post_reset");

        // pwm held high in DRIVE for WDOG_CYCLES cycles
        drive(0, 1, 0, 0, 0, 4'b0000, "idle_to_dead3");
        for (int i = 0; i < DEAD_CYCLES; i++) drive(0, 1, 0, 0, 0, 4'b0010, "dead3");
        drive(0, 1, 0, 0, 0, 4'b0000, "drive_fwd_low");
        for (int i = 0; i < WDOG_CYCLES; i++) drive(0, 1, 0, 0, 1, 4'b1000, "pwm_high_run");
`ifdef HBRIDGE_WDOG_EN
        for (int i = 0; i < 4; i++) begin
            p = 1'(i & 1);
            drive(0, p, 0, 0, 1, 4'b0001, "fault_hold");
        end
        drive(1, 1, 0, 0, 1, 4'b0000, "reset_clears_fault");
`else
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 1, 4'b1000, "no_wdog_drive");
        drive(1, 1, 0, 0, 1, 4'b0000, "reset_end");
`endif
        drive(0, 0, 0, 0, 0, 4'b0000, "final_idle");

        @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hbridge_ctrl.md
HBRIDGE_CTRL -- requirements
Module: hbridge_ctrl

Interface
REQ-001 Parameter: DEAD_CYCLES, 16, dead-time length in clock cycles; legal range 1..255.
REQ-002 Parameter: WDOG_CYCLES, 1024, consecutive pwm_in-high cycles that trip the watchdog; legal range 2..65535.
REQ-003 Port: clock  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: pwm_in  input  1  PWM from the upstream pwm generator.
REQ-006 Port: enable  input  1  1 = drive permitted; 0 = coast.
REQ-007 Port: dir_req  input  1  requested direction; 0 = forward, 1 = reverse.
REQ-008 Port: brake  input  1  1 = request active brake.
REQ-009 Port: in1  output  1  H-bridge input A.
REQ-010 Port: in2  output  1  H-bridge input B.
REQ-011 Port: busy  output  1  high while in DEAD.
REQ-012 Port: fault  output  1  watchdog trip indicator.

Function
REQ-013 The block SHALL implement the states IDLE, DEAD, DRIVE, BRAKE and FAULT; FAULT exists only when HBRIDGE_WDOG_EN is defined.
REQ-014 in1, in2, busy and fault SHALL be registered, giving 1-cycle latency from any input or state change to the outputs.
REQ-015 Output map: IDLE, DEAD and FAULT drive in1=0 and in2=0; BRAKE drives in1=1 and in2=1; DRIVE with dir_q=0 drives in1=pwm_in and in2=0; DRIVE with dir_q=1 drives in1=0 and in2=pwm_in.
REQ-016 enable=0 SHALL move every state except FAULT to IDLE on the next edge; this condition has the highest priority.
REQ-017 IDLE with enable=1 SHALL go to DEAD and load the dead counter with DEAD_CYCLES-1.
REQ-018 DEAD SHALL decrement the counter once per cycle; at count 0 it SHALL exit to BRAKE if brake=1, otherwise to DRIVE, and latch dir_q<=dir_req on that same edge.
REQ-019 dir_req and brake changes during DEAD SHALL have no effect until the DEAD exit edge.
REQ-020 DRIVE with brake=1 SHALL go to DEAD; otherwise DRIVE with dir_req!=dir_q SHALL go to DEAD; both reload the counter to DEAD_CYCLES-1, and brake has priority over a direction change.
REQ-021 BRAKE with brake=0 SHALL go to DEAD with the counter reloaded.
REQ-022 Any switch between a driven pattern (DRIVE or BRAKE) and a different driven pattern SHALL pass through exactly DEAD_CYCLES cycles with in1=in2=0; in1=1 and in2=1 with differing sources is never produced.
REQ-023 busy SHALL be 1 exactly during DEAD.

Reset
REQ-024 While reset=1 the block SHALL hold state=IDLE, dir_q=0, dead counter=0, watchdog counter=0, and in1=in2=busy=fault=0.
REQ-025 Reset asserted mid-DEAD, mid-DRIVE or mid-BRAKE SHALL abort the operation and force the outputs to 0 on the next edge.
REQ-026 Reset SHALL be the only exit from FAULT.

Configuration
REQ-027 The macro HBRIDGE_WDOG_EN SHALL control the watchdog; when it is defined, a 16-bit counter counts consecutive DRIVE cycles with pwm_in=1.
REQ-028 With HBRIDGE_WDOG_EN defined: the counter clears on pwm_in=0 or on any non-DRIVE state; reaching WDOG_CYCLES SHALL enter FAULT and set fault=1 on the next output edge; fault stays 1 until reset.
REQ-029 Without HBRIDGE_WDOG_EN: no watchdog counter and no FAULT state exist, fault is tied to 0, and all other behaviour is identical.

Verification
REQ-030 Scenario: reset, then enable=1, dir_req=0, DEAD_CYCLES=16, pwm_in toggling -> busy=1 for 16 cycles, then in1 follows pwm_in with 1-cycle delay and in2=0.
REQ-031 Scenario: in DRIVE forward, dir_req goes 0->1 -> in1=in2=0 for 16 cycles with busy=1, then in2 follows pwm_in and in1=0.
REQ-032 Scenario: in DRIVE, brake=1 -> 16 dead cycles, then in1=in2=1; brake=0 -> 16 dead cycles, then DRIVE resumes.
REQ-033 Scenario: enable=0 mid-DEAD and again mid-BRAKE -> in1=in2=0 and busy=0 one cycle later, state IDLE.
REQ-034 Scenario: with HBRIDGE_WDOG_EN, WDOG_CYCLES=8 and pwm_in held high in DRIVE -> fault=1 after 8 high cycles and in1=in2=0; enable toggling has no effect; reset clears fault.
REQ-035 Scenario: reset asserted in DRIVE with brake and dir_req changing simultaneously -> all outputs 0 next edge and no shoot-through pattern on any cycle; an in1/in2 assertion checker runs throughout.
